ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter that sends one command byte to the mouse, for example 0xF4 "enable data reporting" or 0xFF "reset".
- It is the opposite direction of the existing mouse receive path.
- It drives the shared ps2_clk/ps2_data open-drain lines through output-enable signals; the top level builds the tri-states.
- It sits beside the mouse controller in the top level and signals busy so the receive path ignores line activity during a host transmission.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_line_sync.sv | 36 +++
 rtl/ps2_host_tx.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 host-transmit types, command constants and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_e;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;

  // Bits driven after the start bit: D0..D7, parity, stop.
  localparam int unsigned SHIFT_W = 10;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 pin plus a falling-edge detector.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall_c
);

  logic meta_q, meta_d;
  logic level_q, level_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d  = pin;
    level_d = meta_q;
    prev_d  = level_q;
  end

  // Idle PS/2 lines float high, so reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q  <= 1'b1;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      meta_q  <= meta_d;
      level_q <= level_d;
      prev_q  <= prev_d;
    end
  end

  assign level  = level_q;
  assign fall_c = prev_q & ~level_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends one command byte
// clocked by the device, checks the device ACK, and reports done/status.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 65_000_000,
  parameter int unsigned INHIBIT_CYCLES = CLK_HZ / 10_000,
  parameter int unsigned REQ_TIMEOUT    = CLK_HZ / 66,
  parameter int unsigned BIT_TIMEOUT    = CLK_HZ / 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > REQ_TIMEOUT) ? INHIBIT_CYCLES : REQ_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = 4;

  logic clk_lvl, clk_fall_c;
  logic data_lvl, data_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk    (clk),
    .rst    (rst),
    .pin    (ps2_clk_in),
    .level  (clk_lvl),
    .fall_c (clk_fall_c)
  );

  ps2_line_sync u_data_sync (
    .clk    (clk),
    .rst    (rst),
    .pin    (ps2_data_in),
    .level  (data_lvl),
    .fall_c (data_fall_unused)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic tx_ready_q, tx_ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic ack_q, ack_d;
  logic err_q, err_d;
  logic clk_oe_q, clk_oe_d;
  logic data_oe_q, data_oe_d;
  logic tmo_c, abort_c;
  logic [CNT_W-1:0] cnt_dec_c;

  assign tmo_c     = (cnt_q <= CNT_W'(1));
  assign cnt_dec_c = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    ack_d     = ack_q;
    err_d     = err_q;
    clk_oe_d  = 1'b0;
    data_oe_d = data_oe_q;
    abort_c   = 1'b0;

    case (state_q)
      IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready_q) begin
          state_d   = INHIBIT;
          shift_d   = {1'b1, odd_parity(tx_data), tx_data};
          cnt_d     = CNT_W'(INHIBIT_CYCLES - 1);
          clk_oe_d  = 1'b1;
          data_oe_d = (INHIBIT_CYCLES == 1);
          ack_d     = 1'b0;
          err_d     = 1'b0;
        end
      end
      // Clock held low; the start bit joins in the last inhibit cycle.
      INHIBIT: begin
        if (cnt_q == '0) begin
          state_d   = REQ;
          cnt_d     = CNT_W'(REQ_TIMEOUT);
          data_oe_d = 1'b1;
        end else begin
          clk_oe_d  = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
          data_oe_d = (cnt_q == CNT_W'(1));
        end
      end
      REQ: begin
        data_oe_d = 1'b1;
        if (clk_fall_c) begin
          state_d   = SHIFT;
          data_oe_d = ~shift_q[0];
          idx_d     = IDX_W'(1);
          cnt_d     = CNT_W'(BIT_TIMEOUT);
        end else if (tmo_c) begin
          abort_c = 1'b1;
        end else begin
          cnt_d = cnt_dec_c;
        end
      end
      SHIFT: begin
        if (clk_fall_c) begin
          data_oe_d = ~shift_q[idx_q];
          idx_d     = idx_q + IDX_W'(1);
          cnt_d     = CNT_W'(BIT_TIMEOUT);
          if (idx_q == IDX_W'(SHIFT_W - 1)) state_d = ACK;
        end else if (tmo_c) begin
          abort_c = 1'b1;
        end else begin
          cnt_d = cnt_dec_c;
        end
      end
      ACK: begin
        if (clk_fall_c) begin
          ack_d   = ~data_lvl;
          state_d = WAIT_IDLE;
          cnt_d   = CNT_W'(BIT_TIMEOUT);
        end else if (tmo_c) begin
          abort_c = 1'b1;
        end else begin
          cnt_d = cnt_dec_c;
        end
      end
      WAIT_IDLE: begin
        if (clk_lvl && data_lvl) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tmo_c) begin
          abort_c = 1'b1;
        end else begin
          cnt_d = cnt_dec_c;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any timeout releases both lines and ends the transaction with an error.
    if (abort_c) begin
      state_d   = IDLE;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b1;
      ack_d     = 1'b0;
      err_d     = 1'b1;
    end

    tx_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_ok      = ack_q;
  assign err_timeout = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on open-drain lines.
module tb_ps2_host_tx;

  localparam int unsigned INH      = 20;
  localparam int unsigned REQT     = 200;
  localparam int unsigned BITT     = 100;
  localparam int          DEV_HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, ack_ok, err_timeout;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt;

  ps2_host_tx #(
    .CLK_HZ         (1_000_000),
    .INHIBIT_CYCLES (INH),
    .REQ_TIMEOUT    (REQT),
    .BIT_TIMEOUT    (BITT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .ack_ok      (ack_ok),
    .err_timeout (err_timeout),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  // Open-drain wired-AND of host and device.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) done_cnt <= 0;
    else if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish expected finish within 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Counts cycles with clk_oe (and data_oe) high; leaves us in the first REQ cycle.
  task automatic count_inhibit(input string tag);
    int n_clk = 0;
    int n_data = 0;
    while (ps2_clk_oe && n_clk < 1000) begin
      n_clk++;
      if (ps2_data_oe) n_data++;
      @(negedge clk);
    end
    check({tag, "_inhibit_len"}, 32'(n_clk), 32'(INH));
    check({tag, "_start_bit_cycles"}, 32'(n_data), 32'd1);
    check({tag, "_req_lines"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b01);
  endtask

  // Device: waits for the request, then gives nclk clock pulses (11 = full frame + ack pulse).
  task automatic dev_frame(input int nclk, input bit do_ack, output logic [9:0] bits, output int last_fall);
    int w = 0;
    bits = '0;
    last_fall = 0;
    while (!(ps2_clk_in && !ps2_data_in) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) check("dev_request_seen", 32'd0, 32'd1);
    repeat (10) @(negedge clk);
    for (int i = 0; i < nclk; i++) begin
      if (i == 10) begin
        dev_data = ~do_ack;
        repeat (5) @(negedge clk);
      end
      dev_clk   = 1'b0;
      last_fall = cyc;
      repeat (DEV_HALF) @(negedge clk);
      if (i < 10) bits[i] = ps2_data_in;
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      if (i < 10) repeat (DEV_HALF) @(negedge clk);
    end
  endtask

  task automatic wait_done(input string tag, input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic finish_txn(input string tag, input logic exp_ack, input logic exp_err);
    int n;
    wait_done(tag, 100, n);
    check({tag, "_status"}, {30'd0, ack_ok, err_timeout}, {30'd0, exp_ack, exp_err});
    check({tag, "_lines_idle"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse_end"}, {31'd0, done}, 32'd0);
    check({tag, "_ready_after"}, {30'd0, tx_ready, busy}, 32'b10);
  endtask

  initial begin
    logic [9:0] bits;
    int lf;
    int n;
    int d0;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {25'd0, tx_ready, busy, done, ack_ok, err_timeout, ps2_clk_oe, ps2_data_oe},
          32'b1000000);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_outputs", {30'd0, tx_ready, busy}, 32'b10);

    // 0xF4: parity 0, ACKed.
    d0 = done_cnt;
    send(8'hF4);
    check("f4_busy", {30'd0, tx_ready, busy}, 32'b01);
    count_inhibit("f4");
    dev_frame(11, 1'b1, bits, lf);
    check("f4_frame", 32'(bits), 32'h2F4);
    finish_txn("f4", 1'b1, 1'b0);
    check("f4_done_count", 32'(done_cnt - d0), 32'd1);

    // 0xFF: parity 1, ACKed.
    send(8'hFF);
    count_inhibit("ff");
    dev_frame(11, 1'b1, bits, lf);
    check("ff_frame", 32'(bits), 32'h3FF);
    finish_txn("ff", 1'b1, 1'b0);

    // 0x00: parity 1, device NACKs.
    send(8'h00);
    count_inhibit("00");
    dev_frame(11, 1'b0, bits, lf);
    check("00_frame", 32'(bits), 32'h300);
    finish_txn("00", 1'b0, 1'b0);

    // No device: request timeout 200 cycles after REQ entry.
    send(8'hF4);
    count_inhibit("noclk");
    wait_done("noclk", 400, n);
    check("noclk_latency", 32'(n), 32'(REQT));
    check("noclk_status", {30'd0, ack_ok, err_timeout}, 32'b01);
    check("noclk_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    repeat (5) @(negedge clk);

    // Device stops after 4 bits: bit timeout.
    send(8'hF4);
    count_inhibit("stall");
    dev_frame(4, 1'b0, bits, lf);
    check("stall_low_bits", 32'(bits[3:0]), 32'h4);
    wait_done("stall", 300, n);
    check("stall_gap_in_window",
          {31'd0, ((cyc - lf) >= 100) && ((cyc - lf) <= 104)}, 32'd1);
    check("stall_status", {30'd0, ack_ok, err_timeout}, 32'b01);
    check("stall_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    repeat (5) @(negedge clk);

    // Asynchronous reset in the middle of SHIFT releases the lines at once.
    send(8'h00);
    count_inhibit("rst");
    dev_frame(3, 1'b0, bits, lf);
    check("rst_pre_data_oe", {31'd0, ps2_data_oe}, 32'd1);
    #2 rst = 1'b0;
    #1 check("rst_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("rst_ready", {30'd0, tx_ready, busy}, 32'b10);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_after_ready", {31'd0, tx_ready}, 32'd1);

    // tx_valid kept high while busy must not start a second frame.
    @(negedge clk);
    tx_data  = 8'hF4;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h55;
    repeat (3) @(negedge clk);
    tx_valid = 1'b0;
    dev_frame(11, 1'b1, bits, lf);
    check("busy_frame", 32'(bits), 32'h2F4);
    finish_txn("busy", 1'b1, 1'b0);
    repeat (300) @(negedge clk);
    check("busy_done_count", 32'(done_cnt), 32'd1);
    check("busy_final_idle", {30'd0, tx_ready, ps2_clk_oe}, 32'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
